sq6_window_acc: RTL and testbench
=================================

Name: sq6_window_acc

Overview:
- Downstream stage of the 6-bit squarer. Consumes one 12-bit square per handshake and accumulates WINDOW consecutive squares into a windowed energy sum.
- Tracks the per-window peak square and flags malformed squares.
- Presents {sum, peak} through a one-entry output buffer with valid/ready handshake, so the next window can accumulate while the previous result waits.

Parameters:
- WINDOW, 16, samples per window; legal range 2..256.
- CNT_W, clog2(WINDOW), window counter width (derived; do not override).
- ACC_W, 12+clog2(WINDOW), accumulator and sum width (derived); overflow cannot occur since 3969*WINDOW < 2^ACC_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards the partial window.
- sq_in  in  12  square from the squarer; bit 11 = y0 (MSB), bit 0 = y11 (LSB).
- in_valid  in  1  sq_in valid.
- in_ready  out  1  block can accept sq_in.
- out_sum  out  ACC_W  sum of WINDOW squares.
- out_peak  out  12  maximum square in the window.
- out_valid  out  1  out_sum/out_peak valid.
- out_ready  in  1  consumer accepts the result.
- fmt_err  out  1  sticky; malformed square seen.

Behaviour:
- Reset (rst_n=0, async):
  - acc=0, cnt=0, peak_acc=0.
  - out_sum=0, out_peak=0, out_valid=0, fmt_err=0, in_ready=1.
  - State = ACCUM, obuf empty.
- Accept: sample is taken when in_valid & in_ready at a rising edge.
- in_ready = !(obuf_full & !out_ready & (cnt==WINDOW-1)). It drops only when the closing sample could not be placed; it is combinational from out_ready.
- States:
  - ACCUM: the only state with cnt < WINDOW-1. On accept: acc += sq_in; peak_acc = max(peak_acc, sq_in); cnt++.
  - CLOSE: cnt == WINDOW-1. On accept, the same edge does all of the following:
    - out_sum <= acc + sq_in
    - out_peak <= max(peak_acc, sq_in)
    - out_valid <= 1
    - acc, peak_acc, cnt <= 0
    - return to ACCUM.
  - Latency from the closing accept to out_valid=1 is 1 cycle.
- Output buffer:
  - out_valid & out_ready at an edge empties it.
  - The same-edge pop and a new closing accept are legal: the new result is loaded and out_valid stays 1.
  - out_sum and out_peak are held stable while out_valid=1 and out_ready=0.
- Back-to-back: with out_ready held 1 and in_valid held 1, one result every WINDOW cycles, with no bubbles.
- Format check:
  - Any accepted sq_in with bit1=1, or sq_in > 3969, sets fmt_err.
  - The sample is still accumulated.
  - fmt_err clears only on reset.
- flush=1 at an edge:
  - Clears acc, peak_acc and cnt; any sample accepted in that cycle is discarded.
  - Does not touch the output buffer, out_valid or fmt_err.
- Reset mid-window or mid-hold: all state is lost immediately. No partial result is emitted.
- Width: acc is unsigned ACC_W. The max comparison is unsigned 12-bit. No saturation logic is needed.

Decomposition:
- Package sq6_pkg holds:
  - SQ_W=12, SQ_MAX=3969
  - function acc_w(window)
  - state enum {ACCUM, CLOSE}
- One sub-module is natural: sq6_out_buf, a one-entry valid/ready register with a simultaneous push/pop path.
- The accumulator, counter, peak and check logic stay in the top.

Test Plan:
- WINDOW=4, out_ready=1, feed 3969 four times back-to-back -> one cycle after the 4th accept: out_sum=15876, out_peak=3969, out_valid=1, fmt_err=0.
- WINDOW=4, feed 1,4,9,16 then 25,36,49,64 continuously, out_ready=1 -> out_sum=30 (peak 16), then exactly 4 cycles later out_sum=174 (peak 64); in_ready never drops.
- WINDOW=4, out_ready=0 after the first result, keep feeding -> 2nd window accumulates and 4th sample of 2nd window stalls with in_ready=0; raise out_ready -> first result popped, second loaded at that same edge, out_valid stays 1.
- Feed 9,16, assert flush one cycle, then feed 1,1,1,1 -> out_sum=4, out_peak=1.
- Accept sq_in=12'h002, then 12'hFFF -> fmt_err=1 after the first, stays 1 through later windows and flush; both values are included in the sum.
- Feed 3 samples, pulse rst_n low asynchronously between edges -> all outputs 0 immediately, in_ready=1; the next 4 samples form a fresh full window.

Source files
------------

// File: rtl/sq6_pkg.sv
// Shared constants, state type and width helper for the squarer back-end stages.
// Imported by sq6_window_acc and sq6_out_buf.
package sq6_pkg;

    localparam int SQ_W   = 12;
    localparam int SQ_MAX = 3969;

    typedef enum logic {
        ACCUM = 1'b0,
        CLOSE = 1'b1
    } acc_state_t;

    function automatic int acc_w(input int window);
        return SQ_W + $clog2(window);
    endfunction

endpackage

// File: rtl/sq6_out_buf.sv
// One-entry result buffer with valid/ready output; a push may coincide with a pop,
// in which case the new result replaces the old one and valid stays high.
module sq6_out_buf
    import sq6_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [ACC_W-1:0] push_sum,
    input  logic [SQ_W-1:0]  push_peak,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [SQ_W-1:0]  out_peak
);

    logic pop;

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_peak  <= '0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_sum   <= push_sum;
            out_peak  <= push_peak;
        end else if (pop) begin
            // Data is left in place after a pop; only valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sq6_window_acc.sv
// Windowed energy accumulator: sums WINDOW squares, tracks the window peak and
// flags malformed squares, handing each {sum, peak} to a one-entry output buffer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACCUM | cnt < WINDOW-1, accepted samples are added into acc/peak
//   CLOSE | cnt == WINDOW-1, next accepted sample closes the window
module sq6_window_acc
    import sq6_pkg::*;
#(
    parameter int WINDOW = 16,
    // Derived widths, not meant to be overridden.
    parameter int CNT_W  = $clog2(WINDOW),
    parameter int ACC_W  = acc_w(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [SQ_W-1:0]  sq_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [SQ_W-1:0]  out_peak,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fmt_err
);

    acc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [SQ_W-1:0]  peak_acc;

    logic             accept;
    logic             sq_bad;
    logic             close_push;
    logic [ACC_W-1:0] sum_next;
    logic [SQ_W-1:0]  peak_next;

    // Only the closing sample can be blocked, and only if the buffer cannot drain now.
    assign in_ready   = !(out_valid && !out_ready && (state == CLOSE));
    assign accept     = in_valid && in_ready;
    assign sq_bad     = sq_in[1] || (sq_in > SQ_W'(SQ_MAX));
    assign sum_next   = acc + ACC_W'(sq_in);
    assign peak_next  = (sq_in > peak_acc) ? sq_in : peak_acc;
    assign close_push = accept && !flush && (state == CLOSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            cnt      <= '0;
            acc      <= '0;
            peak_acc <= '0;
            fmt_err  <= 1'b0;
        end else begin
            if (accept && sq_bad) begin
                fmt_err <= 1'b1;
            end
            if (flush) begin
                state    <= ACCUM;
                cnt      <= '0;
                acc      <= '0;
                peak_acc <= '0;
            end else if (accept) begin
                case (state)
                    ACCUM: begin
                        acc      <= sum_next;
                        peak_acc <= peak_next;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WINDOW - 2)) begin
                            state <= CLOSE;
                        end
                    end
                    CLOSE: begin
                        acc      <= '0;
                        peak_acc <= '0;
                        cnt      <= '0;
                        state    <= ACCUM;
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

    sq6_out_buf #(
        .ACC_W (ACC_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (close_push),
        .push_sum  (sum_next),
        .push_peak (peak_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_peak  (out_peak)
    );

endmodule

// File: tb/tb_sq6_window_acc.sv
// Bench for sq6_window_acc with WINDOW=4: directed vector table, corner sequences
// and randomized traffic, all checked against a window-queue reference model.
module tb_sq6_window_acc;

    localparam int WINDOW = 4;
    localparam int ACC_W  = 12 + $clog2(WINDOW);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [11:0]      sq_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic [11:0]      out_peak;
    logic             out_valid;
    logic             out_ready;
    logic             fmt_err;

    always #5 clk = ~clk;

    sq6_window_acc #(
        .WINDOW (WINDOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .sq_in     (sq_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_peak  (out_peak),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fmt_err   (fmt_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: samples of the open window plus the buffered result.
    int   win_q[$];
    logic m_valid;
    int   m_sum;
    int   m_peak;
    logic m_fmt;
    logic rdy_seen;

    typedef struct {
        logic        iv;
        logic [11:0] sq;
        logic        ordy;
        logic        fl;
        logic        exp_rdy;
        logic        exp_ov;
        int          exp_sum;
        int          exp_peak;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        m_valid = 1'b0;
        m_sum   = 0;
        m_peak  = 0;
        m_fmt   = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle and checks against the model.
    task automatic cycle(input logic iv, input logic [11:0] sq, input logic ordy, input logic fl);
        logic m_rdy, m_acc, m_push;
        in_valid  = iv;
        sq_in     = sq;
        out_ready = ordy;
        flush     = fl;
        #2;
        m_rdy = !(m_valid && !ordy && (win_q.size() == WINDOW - 1));
        rdy_seen = in_ready;
        chk("in_ready", in_ready, m_rdy);
        m_acc  = iv && m_rdy;
        m_push = 1'b0;
        if (m_acc && (sq[1] || sq > 12'd3969)) m_fmt = 1'b1;
        if (fl) begin
            win_q.delete();
        end else if (m_acc) begin
            win_q.push_back(int'(sq));
            if (win_q.size() == WINDOW) begin
                m_sum  = 0;
                m_peak = 0;
                foreach (win_q[i]) begin
                    m_sum += win_q[i];
                    if (win_q[i] > m_peak) m_peak = win_q[i];
                end
                m_valid = 1'b1;
                m_push  = 1'b1;
                win_q.delete();
            end
        end
        if (!m_push && m_valid && ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_sum", out_sum, m_sum);
        chk("out_peak", out_peak, m_peak);
        chk("fmt_err", fmt_err, m_fmt);
    endtask

    initial begin
        // iv, sq, ordy, fl | rdy, ov, sum, peak
        tbl.push_back(vec_t'{1'b1, 12'd3969, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 12'd3969, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 12'd3969, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 12'd3969, 1'b1, 1'b0, 1'b1, 1'b1, 15876, 3969});
        tbl.push_back(vec_t'{1'b0, 12'd0,    1'b1, 1'b0, 1'b1, 1'b0, 15876, 3969});
        tbl.push_back(vec_t'{1'b1, 12'd1,    1'b1, 1'b0, 1'b1, 1'b0, 15876, 3969});
        tbl.push_back(vec_t'{1'b1, 12'd4,    1'b1, 1'b0, 1'b1, 1'b0, 15876, 3969});
        tbl.push_back(vec_t'{1'b1, 12'd9,    1'b1, 1'b0, 1'b1, 1'b0, 15876, 3969});
        tbl.push_back(vec_t'{1'b1, 12'd16,   1'b1, 1'b0, 1'b1, 1'b1, 30, 16});
        tbl.push_back(vec_t'{1'b1, 12'd25,   1'b1, 1'b0, 1'b1, 1'b0, 30, 16});
        tbl.push_back(vec_t'{1'b1, 12'd36,   1'b1, 1'b0, 1'b1, 1'b0, 30, 16});
        tbl.push_back(vec_t'{1'b1, 12'd49,   1'b1, 1'b0, 1'b1, 1'b0, 30, 16});
        tbl.push_back(vec_t'{1'b1, 12'd64,   1'b1, 1'b0, 1'b1, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd0,    1'b0, 1'b0, 1'b1, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd1,    1'b0, 1'b0, 1'b1, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd4,    1'b0, 1'b0, 1'b1, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd9,    1'b0, 1'b0, 1'b0, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd9,    1'b0, 1'b0, 1'b0, 1'b1, 174, 64});
        tbl.push_back(vec_t'{1'b1, 12'd9,    1'b1, 1'b0, 1'b1, 1'b1, 14, 9});
        tbl.push_back(vec_t'{1'b0, 12'd0,    1'b1, 1'b0, 1'b1, 1'b0, 14, 9});

        rst_n     = 1'b0;
        flush     = 1'b0;
        sq_in     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_reset();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_peak", out_peak, 0);
        chk("rst_fmt_err", fmt_err, 0);
        chk("rst_in_ready", in_ready, 1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            cycle(tbl[i].iv, tbl[i].sq, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_in_ready", i), rdy_seen, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_out_sum", i), out_sum, tbl[i].exp_sum);
            chk($sformatf("tbl%0d_out_peak", i), out_peak, tbl[i].exp_peak);
        end

        // Flush discards a partial window, including a sample accepted with it.
        cycle(1'b1, 12'd9, 1'b1, 1'b0);
        cycle(1'b1, 12'd16, 1'b1, 1'b0);
        cycle(1'b0, 12'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'd1, 1'b1, 1'b0);
        chk("flush_sum", out_sum, 4);
        chk("flush_peak", out_peak, 1);
        chk("flush_valid", out_valid, 1);
        cycle(1'b1, 12'd25, 1'b1, 1'b0);
        cycle(1'b1, 12'd100, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'd4, 1'b1, 1'b0);
        chk("flush2_sum", out_sum, 16);
        chk("flush2_peak", out_peak, 4);

        // Malformed squares set the sticky flag but are still summed.
        cycle(1'b1, 12'h002, 1'b1, 1'b0);
        chk("fmt_after_first", fmt_err, 1);
        cycle(1'b1, 12'hFFF, 1'b1, 1'b0);
        cycle(1'b1, 12'd1, 1'b1, 1'b0);
        cycle(1'b1, 12'd1, 1'b1, 1'b0);
        chk("fmt_sum", out_sum, 4099);
        chk("fmt_peak", out_peak, 4095);
        cycle(1'b0, 12'd0, 1'b1, 1'b1);
        chk("fmt_after_flush", fmt_err, 1);

        // Asynchronous reset mid-window.
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'd4, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_peak", out_peak, 0);
        chk("arst_fmt_err", fmt_err, 0);
        chk("arst_in_ready", in_ready, 1);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'd9, 1'b1, 1'b0);
        chk("arst_fresh_sum", out_sum, 36);
        chk("arst_fresh_peak", out_peak, 9);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] rs;
            int r;
            r  = int'($urandom_range(0, 63));
            rs = ($urandom_range(0, 19) == 0) ? 12'($urandom) : 12'(r * r);
            cycle(($urandom_range(0, 3) != 0), rs, ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
